// File: rtl/req_arbiter.sv
// Round-robin arbiter sharing one Wishbone request bridge among NREQ requesters.
// The owner holds the bridge from request handshake until its last data beat.
module req_arbiter #(
  parameter int NREQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    s_req_valid,
  output logic [NREQ-1:0]    s_req_ready,
  input  logic [NREQ*32-1:0] s_req_addr,
  input  logic [NREQ*4-1:0]  s_req_mask,
  input  logic [NREQ*3-1:0]  s_req_len,
  input  logic [NREQ-1:0]    s_req_we,
  input  logic [NREQ-1:0]    s_req_wrap,
  input  logic [NREQ-1:0]    s_write_valid,
  input  logic [NREQ*32-1:0] s_write_data,
  output logic [NREQ-1:0]    s_read_valid,
  output logic [NREQ*32-1:0] s_read_data,
  input  logic [NREQ-1:0]    s_read_ack,
  output logic               m_req_valid,
  input  logic               m_req_ready,
  output logic [31:0]        m_req_addr,
  output logic [3:0]         m_req_mask,
  output logic [2:0]         m_req_len,
  output logic               m_req_we,
  output logic               m_req_wrap,
  output logic               m_write_valid,
  output logic [31:0]        m_write_data,
  input  logic               m_read_valid,
  input  logic [31:0]        m_read_data,
  output logic               m_read_ack,
  output logic [NREQ-1:0]    grant
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            we_q, we_d;

  logic            arb_found;
  logic [PW-1:0]   arb_idx;
  logic [PW-1:0]   ptr_nxt;
  logic            beat;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_q) + i) % NREQ;
      if (!arb_found && s_req_valid[j]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(j);
      end
    end
  end

  assign ptr_nxt = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
  assign beat    = we_q ? m_write_valid : m_read_ack;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d          = REQ;
          win_d            = arb_idx;
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
        end
      end
      REQ: begin
        if (!s_req_valid[win_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (m_req_ready) begin
          state_d = DATA;
          we_d    = s_req_we[win_q];
          cnt_d   = s_req_len[3*win_q +: 3];
        end
      end
      DATA: begin
        // counter wraps 0 -> 7, so len 0 yields eight beats
        if (beat) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = ptr_nxt;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    s_req_ready   = '0;
    s_read_valid  = '0;
    m_req_valid   = 1'b0;
    m_write_valid = 1'b0;
    m_read_ack    = 1'b0;
    m_req_addr    = s_req_addr[32*win_q +: 32];
    m_req_mask    = s_req_mask[4*win_q +: 4];
    m_req_len     = s_req_len[3*win_q +: 3];
    m_req_we      = s_req_we[win_q];
    m_req_wrap    = s_req_wrap[win_q];
    m_write_data  = s_write_data[32*win_q +: 32];
    s_read_data   = {NREQ{m_read_data}};
    unique case (1'b1)
      state_q == REQ: begin
        m_req_valid        = s_req_valid[win_q];
        s_req_ready[win_q] = m_req_ready;
      end
      state_q == DATA && we_q: begin
        m_write_valid = s_write_valid[win_q];
      end
      state_q == DATA && !we_q: begin
        s_read_valid[win_q] = m_read_valid;
        m_read_ack          = s_read_ack[win_q] & m_read_valid;
      end
      default: begin
      end
    endcase
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Scoreboard bench for req_arbiter: directed bursts, the bench acts as requesters
// and as the bridge; a negedge monitor checks every handshake against a queue.
module tb_req_arbiter;

  localparam int N = 2;
  localparam int K_REQ = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  s_req_valid;
  logic [N-1:0]  s_req_ready;
  logic [N*32-1:0] s_req_addr;
  logic [N*4-1:0]  s_req_mask;
  logic [N*3-1:0]  s_req_len;
  logic [N-1:0]  s_req_we;
  logic [N-1:0]  s_req_wrap;
  logic [N-1:0]  s_write_valid;
  logic [N*32-1:0] s_write_data;
  logic [N-1:0]  s_read_valid;
  logic [N*32-1:0] s_read_data;
  logic [N-1:0]  s_read_ack;
  logic          m_req_valid;
  logic          m_req_ready;
  logic [31:0]   m_req_addr;
  logic [3:0]    m_req_mask;
  logic [2:0]    m_req_len;
  logic          m_req_we;
  logic          m_req_wrap;
  logic          m_write_valid;
  logic [31:0]   m_write_data;
  logic          m_read_valid;
  logic [31:0]   m_read_data;
  logic          m_read_ack;
  logic [N-1:0]  grant;

  req_arbiter #(.NREQ(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(s_req_addr), .s_req_mask(s_req_mask),
    .s_req_len(s_req_len), .s_req_we(s_req_we),
    .s_req_wrap(s_req_wrap),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data),
    .s_read_ack(s_read_ack),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_mask(m_req_mask),
    .m_req_len(m_req_len), .m_req_we(m_req_we),
    .m_req_wrap(m_req_wrap),
    .m_write_valid(m_write_valid), .m_write_data(m_write_data),
    .m_read_valid(m_read_valid), .m_read_data(m_read_data),
    .m_read_ack(m_read_ack),
    .grant(grant)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          kind;
    logic [N-1:0] sel;
    logic [31:0] data;
    logic [2:0]  len;
    logic        we;
  } ev_t;

  ev_t sbq[$];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic push(input int kind, input logic [N-1:0] sel,
                      input logic [31:0] d, input logic [2:0] len,
                      input logic we);
    ev_t e;
    e.kind = kind;
    e.sel  = sel;
    e.data = d;
    e.len  = len;
    e.we   = we;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    int  idx;
    if (sbq.size() == 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL sb_unexpected kind=%0d t=%0t", kind, $time);
      return;
    end
    e = sbq.pop_front();
    chk("sb_kind", 64'(kind), 64'(e.kind));
    idx = e.sel[1] ? 1 : 0;
    case (kind)
      K_REQ: begin
        chk("req_grant", 64'(grant), 64'(e.sel));
        chk("req_addr", 64'(m_req_addr), 64'(e.data));
        chk("req_len", 64'(m_req_len), 64'(e.len));
        chk("req_we", 64'(m_req_we), 64'(e.we));
        chk("req_mask", 64'(m_req_mask), e.we ? 64'hF : 64'h3);
        chk("req_wrap", 64'(m_req_wrap), 64'(!e.we));
      end
      K_WR: chk("wr_data", 64'(m_write_data), 64'(e.data));
      default: begin
        chk("rd_valid", 64'(s_read_valid), 64'(e.sel));
        chk("rd_data", 64'(s_read_data[idx*32 +: 32]), 64'(e.data));
      end
    endcase
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_req_valid && m_req_ready) pop_cmp(K_REQ);
      if (m_write_valid) pop_cmp(K_WR);
      if (m_read_ack) pop_cmp(K_RD);
    end
  end

  task automatic chk_quiet(input string nm);
    chk({nm, "_grant"}, 64'(grant), 64'h0);
    chk({nm, "_sready"}, 64'(s_req_ready), 64'h0);
    chk({nm, "_mvalid"}, 64'(m_req_valid), 64'h0);
    chk({nm, "_wvalid"}, 64'(m_write_valid), 64'h0);
    chk({nm, "_rack"}, 64'(m_read_ack), 64'h0);
    chk({nm, "_rvalid"}, 64'(s_read_valid), 64'h0);
  endtask

  task automatic issue(input int k, input logic [31:0] addr,
                       input logic [2:0] len, input logic we,
                       input bit lat);
    bit got;
    got = 1'b0;
    push(K_REQ, oh(k), addr, len, we);
    @(posedge clk_i);
    #1;
    s_req_valid[k]         = 1'b1;
    s_req_addr[k*32 +: 32] = addr;
    s_req_len[k*3 +: 3]    = len;
    s_req_mask[k*4 +: 4]   = we ? 4'hF : 4'h3;
    s_req_we[k]            = we;
    s_req_wrap[k]          = !we;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk_i);
      if (lat && w < 2) chk("req_latency", 64'(m_req_valid), 64'(w == 1));
      if (s_req_ready[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("req_timeout", 64'(got), 64'h1);
    @(posedge clk_i);
    #1;
    s_req_valid[k] = 1'b0;
  endtask

  task automatic read_beats(input int k, input int n,
                            input logic [31:0] base, input int stall_at);
    bit got;
    s_read_ack[k] = 1'b1;
    for (int b = 0; b < n; b++) begin
      m_read_valid = 1'b1;
      m_read_data  = base + 32'(b);
      if (b == stall_at) begin
        s_read_ack[k] = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk_i);
          chk("stall_ack", 64'(m_read_ack), 64'h0);
          chk("stall_grant", 64'(grant), 64'(oh(k)));
        end
        @(posedge clk_i);
        #1;
        s_read_ack[k] = 1'b1;
      end
      got = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk_i);
        if (m_read_ack) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        chk("rd_timeout", 64'(got), 64'h1);
        break;
      end
      @(posedge clk_i);
      #1;
    end
    m_read_valid  = 1'b0;
    s_read_ack[k] = 1'b0;
  endtask

  // both requesters contend with len-1 reads; period is IDLE, REQ, DATA
  task automatic rr(input int first, input int nb);
    int o;
    @(posedge clk_i);
    #1;
    for (int b = 0; b < nb; b++) begin
      o = (first + b) % N;
      push(K_REQ, oh(o), 32'h200 + 32'(o) * 32'h100, 3'd1, 1'b0);
      push(K_RD, oh(o), 32'h5A5A_0000, 3'd0, 1'b0);
    end
    for (int k = 0; k < N; k++) begin
      s_req_addr[k*32 +: 32] = 32'h200 + 32'(k) * 32'h100;
      s_req_len[k*3 +: 3]    = 3'd1;
      s_req_mask[k*4 +: 4]   = 4'h3;
      s_req_we[k]            = 1'b0;
      s_req_wrap[k]          = 1'b1;
    end
    s_req_valid  = '1;
    s_read_ack   = '1;
    m_read_valid = 1'b1;
    m_read_data  = 32'h5A5A_0000;
    for (int c = 0; c < 3 * nb; c++) begin
      o = (first + c / 3) % N;
      @(negedge clk_i);
      case (c % 3)
        0: begin
          chk("rr_idle_grant", 64'(grant), 64'h0);
          chk("rr_idle_rvalid", 64'(s_read_valid), 64'h0);
        end
        1: begin
          chk("rr_req_grant", 64'(grant), 64'(oh(o)));
          chk("rr_req_rack", 64'(m_read_ack), 64'h0);
          chk("rr_req_rvalid", 64'(s_read_valid), 64'h0);
        end
        default: begin
          chk("rr_data_grant", 64'(grant), 64'(oh(o)));
          chk("rr_data_rack", 64'(m_read_ack), 64'h1);
        end
      endcase
    end
    @(posedge clk_i);
    #1;
    s_req_valid  = '0;
    s_read_ack   = '0;
    m_read_valid = 1'b0;
    @(negedge clk_i);
    chk("rr_end_grant", 64'(grant), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i         = 1'b1;
    s_req_valid   = '1;
    s_req_addr    = '0;
    s_req_mask    = '0;
    s_req_len     = '0;
    s_req_we      = '0;
    s_req_wrap    = '0;
    s_write_valid = '0;
    s_write_data  = '0;
    s_read_ack    = '1;
    m_req_ready   = 1'b1;
    m_read_valid  = 1'b1;
    m_read_data   = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_quiet("reset");
    @(posedge clk_i);
    #1;
    rst_i        = 1'b0;
    s_req_valid  = '0;
    s_read_ack   = '0;
    m_read_valid = 1'b0;

    // single 4-beat read from requester 0
    issue(0, 32'h100, 3'd4, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) push(K_RD, 2'b01, 32'hC000_0000 + 32'(b), 3'd0, 1'b0);
    read_beats(0, 4, 32'hC000_0000, -1);
    @(negedge clk_i);
    chk_quiet("rd_done");

    // requester 1 withdraws before the handshake; ptr must stay at 1
    m_req_ready = 1'b0;
    @(posedge clk_i);
    #1;
    s_req_valid[1] = 1'b1;
    s_req_addr[63:32] = 32'h0BAD_0000;
    @(posedge clk_i);
    #1;
    s_req_valid[1] = 1'b0;
    @(negedge clk_i);
    chk("wd_grant", 64'(grant), 64'h2);
    chk("wd_mvalid", 64'(m_req_valid), 64'h0);
    @(negedge clk_i);
    chk("wd_idle_grant", 64'(grant), 64'h0);
    m_req_ready = 1'b1;

    rr(1, 4);

    // len 0 write from requester 1, requester 0 drives stray beats
    issue(1, 32'h500, 3'd0, 1'b1, 1'b0);
    for (int b = 0; b < 8; b++) push(K_WR, 2'b10, 32'hA000_0000 + 32'(b), 3'd0, 1'b1);
    for (int b = 0; b < 8; b++) begin
      s_write_valid       = 2'b11;
      s_write_data[63:32] = 32'hA000_0000 + 32'(b);
      s_write_data[31:0]  = 32'hDEAD_BEEF;
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    chk("wr_end_wvalid", 64'(m_write_valid), 64'h0);
    chk("wr_end_grant", 64'(grant), 64'h0);
    s_write_valid = '0;

    // read with five stalled ack cycles before beat 2
    issue(0, 32'h600, 3'd4, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) push(K_RD, 2'b01, 32'hB000_0000 + 32'(b), 3'd0, 1'b0);
    read_beats(0, 4, 32'hB000_0000, 2);
    @(negedge clk_i);
    chk_quiet("bp_done");

    // reset during beat 2 of a 4-beat read
    issue(0, 32'h700, 3'd4, 1'b0, 1'b0);
    for (int b = 0; b < 2; b++) push(K_RD, 2'b01, 32'hD000_0000 + 32'(b), 3'd0, 1'b0);
    read_beats(0, 2, 32'hD000_0000, -1);
    m_read_valid  = 1'b1;
    m_read_data   = 32'hD000_0002;
    s_read_ack[0] = 1'b1;
    rst_i         = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_quiet("mid_rst");
    m_read_valid = 1'b0;
    s_read_ack   = '0;

    rr(0, 2);

    repeat (2) @(negedge clk_i);
    chk("sb_leftover", 64'(sbq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
